// File: rtl/alu_5_pkg.sv
// Shared constants for the 4-bit registered ALU: datapath width and opcode encodings.
package alu_5_pkg;

   localparam int unsigned ALU_W = 4;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_NOT  = 4'b0100;
   localparam logic [3:0] OP_NAND = 4'b0101;
   localparam logic [3:0] OP_SHL  = 4'b0110;
   localparam logic [3:0] OP_SHR  = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_XNOR = 4'b1001;

endpackage

// File: rtl/alu_5_comb.sv
// Combinational core of alu_5: result and carry/zero/negative flags from operands and opcode.
module alu_5_comb
   import alu_5_pkg::*;
(
   input  logic [ALU_W-1:0] i_a,
   input  logic [ALU_W-1:0] i_b,
   input  logic [3:0]       i_sel,
   output logic [ALU_W-1:0] o_r,
   output logic             o_c,
   output logic             o_z,
   output logic             o_n
);

   logic [ALU_W:0] w_sum;
   logic [ALU_W:0] w_diff;
   logic           w_shift_oob;

   assign w_sum       = {1'b0, i_a} + {1'b0, i_b};
   // Bit 4 of the zero-extended difference is set exactly when a < b (borrow).
   assign w_diff      = {1'b0, i_a} - {1'b0, i_b};
   assign w_shift_oob = (i_b >= 4'd4);

   always_comb begin
      o_r = '0;
      o_c = 1'b0;
      case (i_sel)
         OP_ADD: begin
            o_r = w_sum[ALU_W-1:0];
            o_c = w_sum[ALU_W];
         end
         OP_SUB: begin
            o_r = w_diff[ALU_W-1:0];
            o_c = w_diff[ALU_W];
         end
         OP_AND:  o_r = i_a & i_b;
         OP_OR:   o_r = i_a | i_b;
         OP_NOT:  o_r = ~i_a;
         OP_NAND: o_r = ~(i_a & i_b);
         OP_SHL:  o_r = w_shift_oob ? '0 : (i_a << i_b[1:0]);
         OP_SHR:  o_r = w_shift_oob ? '0 : (i_a >> i_b[1:0]);
         OP_XOR:  o_r = i_a ^ i_b;
         OP_XNOR: o_r = ~(i_a ^ i_b);
         default: begin
            o_r = '0;
            o_c = 1'b0;
         end
      endcase
   end

   assign o_z = (o_r == '0);
   assign o_n = o_r[ALU_W-1];

endmodule

// File: rtl/alu_5.sv
// Registered 4-bit ALU: one-cycle latency, synchronous active-high reset to Y=0 with Z set.
module alu_5
   import alu_5_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [ALU_W-1:0] A,
   input  logic [ALU_W-1:0] B,
   input  logic [3:0]       sel,
   output logic [ALU_W-1:0] Y,
   output logic             C_out,
   output logic             Z_out,
   output logic             N_out
);

   logic [ALU_W-1:0] w_r;
   logic             w_c;
   logic             w_z;
   logic             w_n;

   logic [ALU_W-1:0] r_y;
   logic             r_c;
   logic             r_z;
   logic             r_n;

   alu_5_comb u_comb (
      .i_a   (A),
      .i_b   (B),
      .i_sel (sel),
      .o_r   (w_r),
      .o_c   (w_c),
      .o_z   (w_z),
      .o_n   (w_n)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_y <= '0;
         r_c <= 1'b0;
         r_z <= 1'b1;
         r_n <= 1'b0;
      end else begin
         r_y <= w_r;
         r_c <= w_c;
         r_z <= w_z;
         r_n <= w_n;
      end
   end

   assign Y     = r_y;
   assign C_out = r_c;
   assign Z_out = r_z;
   assign N_out = r_n;

endmodule

// File: tb/tb_alu_5.sv
// Directed bench for alu_5: each step applies one operation and checks {Y,C,Z,N} one edge later.
module tb_alu_5;
   import alu_5_pkg::*;

   logic       clk;
   logic       rst;
   logic [3:0] A;
   logic [3:0] B;
   logic [3:0] sel;
   logic [3:0] Y;
   logic       C_out;
   logic       Z_out;
   logic       N_out;

   int n_chk;
   int n_pass;

   alu_5 dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .sel   (sel),
      .Y     (Y),
      .C_out (C_out),
      .Z_out (Z_out),
      .N_out (N_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive on the falling edge, capture on the rising edge, sample 1 time unit later.
   task automatic step(input string tag, input logic r, input logic [3:0] op,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ey, input logic ec, input logic ez, input logic en);
      logic [6:0] obs;
      logic [6:0] exp;
      @(negedge clk);
      rst = r;
      sel = op;
      A   = a;
      B   = b;
      @(posedge clk);
      #1;
      obs = {Y, C_out, Z_out, N_out};
      exp = {ey, ec, ez, en};
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed Y/C/Z/N=%b/%b/%b/%b expected %b/%b/%b/%b",
                  tag, obs[6:3], obs[2], obs[1], obs[0], ey, ec, ez, en);
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst = 1'b1;
      A   = 4'd0;
      B   = 4'd0;
      sel = OP_ADD;

      // Reset with a live operation on the inputs; it must be discarded.
      step("reset",        1'b1, OP_ADD,  4'd9,    4'd3,    4'b0000, 1'b0, 1'b1, 1'b0);
      step("add_4_2",      1'b0, OP_ADD,  4'd4,    4'd2,    4'b0110, 1'b0, 1'b0, 1'b0);
      step("add_9_7",      1'b0, OP_ADD,  4'd9,    4'd7,    4'b0000, 1'b1, 1'b1, 1'b0);
      step("add_9_3",      1'b0, OP_ADD,  4'd9,    4'd3,    4'b1100, 1'b0, 1'b0, 1'b1);
      step("add_0_0",      1'b0, OP_ADD,  4'd0,    4'd0,    4'b0000, 1'b0, 1'b1, 1'b0);
      step("add_15_15",    1'b0, OP_ADD,  4'd15,   4'd15,   4'b1110, 1'b1, 1'b0, 1'b1);
      step("sub_0_0",      1'b0, OP_SUB,  4'd0,    4'd0,    4'b0000, 1'b0, 1'b1, 1'b0);
      step("sub_2_5",      1'b0, OP_SUB,  4'd2,    4'd5,    4'b1101, 1'b1, 1'b0, 1'b1);
      step("sub_4_1",      1'b0, OP_SUB,  4'd4,    4'd1,    4'b0011, 1'b0, 1'b0, 1'b0);
      step("sub_7_7",      1'b0, OP_SUB,  4'd7,    4'd7,    4'b0000, 1'b0, 1'b1, 1'b0);
      step("and_2_1",      1'b0, OP_AND,  4'b0010, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);
      step("and_a_b",      1'b0, OP_AND,  4'b1010, 4'b1011, 4'b1010, 1'b0, 1'b0, 1'b1);
      step("or_a_b",       1'b0, OP_OR,   4'b1010, 4'b1011, 4'b1011, 1'b0, 1'b0, 1'b1);
      step("or_0_0",       1'b0, OP_OR,   4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
      step("not_0",        1'b0, OP_NOT,  4'b0000, 4'b0101, 4'b1111, 1'b0, 1'b0, 1'b1);
      step("not_f",        1'b0, OP_NOT,  4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
      step("nand_a_b",     1'b0, OP_NAND, 4'b1010, 4'b1011, 4'b0101, 1'b0, 1'b0, 1'b0);
      step("shl_1_2",      1'b0, OP_SHL,  4'b0001, 4'd2,    4'b0100, 1'b0, 1'b0, 1'b0);
      step("shl_3_3",      1'b0, OP_SHL,  4'b0011, 4'd3,    4'b1000, 1'b0, 1'b0, 1'b1);
      step("shl_1_5",      1'b0, OP_SHL,  4'b0001, 4'd5,    4'b0000, 1'b0, 1'b1, 1'b0);
      step("shl_f_4",      1'b0, OP_SHL,  4'b1111, 4'd4,    4'b0000, 1'b0, 1'b1, 1'b0);
      step("shr_8_2",      1'b0, OP_SHR,  4'b1000, 4'd2,    4'b0010, 1'b0, 1'b0, 1'b0);
      step("shr_8_5",      1'b0, OP_SHR,  4'b1000, 4'd5,    4'b0000, 1'b0, 1'b1, 1'b0);
      step("shr_f_4",      1'b0, OP_SHR,  4'b1111, 4'd4,    4'b0000, 1'b0, 1'b1, 1'b0);
      step("shr_f_0",      1'b0, OP_SHR,  4'b1111, 4'd0,    4'b1111, 1'b0, 1'b0, 1'b1);
      step("xor_8_8",      1'b0, OP_XOR,  4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0);
      step("xor_8_4",      1'b0, OP_XOR,  4'b1000, 4'b0100, 4'b1100, 1'b0, 1'b0, 1'b1);
      step("xnor_8_8",     1'b0, OP_XNOR, 4'b1000, 4'b1000, 4'b1111, 1'b0, 1'b0, 1'b1);
      step("xnor_8_7",     1'b0, OP_XNOR, 4'b1000, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b0);
      step("rsv_f",        1'b0, 4'b1111, 4'd15,   4'd15,   4'b0000, 1'b0, 1'b1, 1'b0);
      step("rsv_a",        1'b0, 4'b1010, 4'd9,    4'd7,    4'b0000, 1'b0, 1'b1, 1'b0);
      step("add_pre_rst",  1'b0, OP_ADD,  4'd15,   4'd15,   4'b1110, 1'b1, 1'b0, 1'b1);
      step("reset_mid",    1'b1, OP_NOT,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
      step("post_rst_sub", 1'b0, OP_SUB,  4'd2,    4'd5,    4'b1101, 1'b1, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
